// File: rtl/fft8_out_serializer.sv
// Ping-pong parallel-to-serial output stage of the 8-point FFT: one frame of 8 complex bins in, one bin per cycle out in natural order.
// Latency: bin 0 valid the cycle after capture. Backpressure: out_ready low holds the output; in_ready drops only while both banks are full.
module fft8_out_serializer #(
  parameter int DATA_WIDTH  = 16,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*DATA_WIDTH-1:0]      in_re,
  input  logic [8*DATA_WIDTH-1:0]      in_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic [2:0]                   out_idx,
  output logic                         out_last
);
  localparam int DW = DATA_WIDTH;

  logic signed [DW-1:0] bank_re_q [2][8];
  logic signed [DW-1:0] bank_re_d [2][8];
  logic signed [DW-1:0] bank_im_q [2][8];
  logic signed [DW-1:0] bank_im_d [2][8];
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [2:0]           rd_idx_q, rd_idx_d;
  logic                 accept, xfer;

  // Input slot holding natural-order bin k.
  function automatic logic [2:0] slot_of(input logic [2:0] k);
    return BIT_REVERSE ? {k[0], k[1], k[2]} : k;
  endfunction

  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign out_re    = bank_re_q[rd_sel_q][rd_idx_q];
  assign out_im    = bank_im_q[rd_sel_q][rd_idx_q];
  assign out_idx   = rd_idx_q;
  assign out_last  = out_valid && (rd_idx_q == 3'd7);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    bank_re_d = bank_re_q;
    bank_im_d = bank_im_q;
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    rd_idx_d  = rd_idx_q;
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        bank_re_d[wr_sel_q][k] = in_re[int'(slot_of(3'(k)))*DW +: DW];
        bank_im_d[wr_sel_q][k] = in_im[int'(slot_of(3'(k)))*DW +: DW];
      end
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    // The full flags keep the capture bank and the draining bank distinct.
    if (xfer) begin
      rd_idx_d = rd_idx_q + 3'd1;
      if (rd_idx_q == 3'd7) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          bank_re_q[b][k] <= '0;
          bank_im_q[b][k] <= '0;
        end
      end
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_idx_q <= 3'd0;
    end else begin
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      rd_idx_q  <= rd_idx_d;
    end
  end
endmodule

// File: tb/tb_fft8_out_serializer.sv
// Scoreboard bench: two instances (bit-reversed and plain slot order) share data buses; a monitor pops expected bins per transfer.
module tb_fft8_out_serializer;
  localparam int DW = 16;
  localparam int BRV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct packed {
    logic [2:0]    idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } bin_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [8*DW-1:0] in_re = '0, in_im = '0;
  logic in_valid_br = 1'b0, in_valid_nr = 1'b0, out_ready = 1'b0;
  logic in_ready_br, out_valid_br, out_last_br, in_ready_nr, out_valid_nr, out_last_nr;
  logic signed [DW-1:0] out_re_br, out_im_br, out_re_nr, out_im_nr;
  logic [2:0] out_idx_br, out_idx_nr;

  int n_checks = 0, n_fail = 0;
  bin_t q_br[$], q_nr[$];
  bit   prev_stall [2];
  bin_t prev_bin [2];

  always #5 clk = ~clk;

  fft8_out_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b1)) u_br (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid_br), .in_ready(in_ready_br),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_br), .out_ready(out_ready),
    .out_re(out_re_br), .out_im(out_im_br), .out_idx(out_idx_br), .out_last(out_last_br));

  fft8_out_serializer #(.DATA_WIDTH(DW), .BIT_REVERSE(1'b0)) u_nr (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid_nr), .in_ready(in_ready_nr),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_nr), .out_ready(out_ready),
    .out_re(out_re_nr), .out_im(out_im_nr), .out_idx(out_idx_nr), .out_last(out_last_nr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int nr, input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                     input logic [2:0] idx, input logic last);
    bin_t cur, e;
    cur = '{idx: idx, re: re, im: im, last: last};
    if (prev_stall[nr]) begin
      chk(nr ? "nr_stall_valid" : "br_stall_valid", 32'(v), 32'd1);
      chk(nr ? "nr_stall_hold" : "br_stall_hold", 32'(cur), 32'(prev_bin[nr]));
    end
    if (!v) chk(nr ? "nr_last_idle" : "br_last_idle", 32'(last), 32'd0);
    if (v && out_ready) begin
      if ((nr ? q_nr.size() : q_br.size()) == 0) begin
        chk(nr ? "nr_unexpected_bin" : "br_unexpected_bin", 32'(cur), 32'hFFFF_FFFF);
      end else begin
        e = nr ? q_nr.pop_front() : q_br.pop_front();
        chk(nr ? "nr_bin_idx" : "br_bin_idx", 32'(idx), 32'(e.idx));
        chk(nr ? "nr_bin_re" : "br_bin_re", 32'(re), 32'(e.re));
        chk(nr ? "nr_bin_im" : "br_bin_im", 32'(im), 32'(e.im));
        chk(nr ? "nr_bin_last" : "br_bin_last", 32'(last), 32'(e.last));
      end
    end
    prev_stall[nr] = v && !out_ready;
    prev_bin[nr]   = cur;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!arst_n) begin
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
      end else begin
        mon(0, out_valid_br, out_re_br, out_im_br, out_idx_br, out_last_br);
        mon(1, out_valid_nr, out_re_nr, out_im_nr, out_idx_nr, out_last_nr);
      end
    end
  end

  // Presents a frame from a negedge, holds it until accepted, pushes the expected bins and returns on the next negedge.
  task automatic send(input bit nr, input logic [8*DW-1:0] re, input logic [8*DW-1:0] im);
    bin_t e;
    bit ok = 1'b0;
    in_re = re;
    in_im = im;
    if (nr) in_valid_nr = 1'b1; else in_valid_br = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (nr ? in_ready_nr : in_ready_br) begin
        for (int k = 0; k < 8; k++) begin
          e.idx  = 3'(k);
          e.re   = re[(nr ? k : BRV[k])*DW +: DW];
          e.im   = im[(nr ? k : BRV[k])*DW +: DW];
          e.last = (k == 7);
          if (nr) q_nr.push_back(e); else q_br.push_back(e);
        end
        ok = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid_br = 1'b0;
    in_valid_nr = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      #3;
      done = (q_br.size() == 0) && (q_nr.size() == 0) && !out_valid_br && !out_valid_nr;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  function automatic logic [8*DW-1:0] pack_frame(input int base, input int step);
    logic [8*DW-1:0] v;
    for (int s = 0; s < 8; s++) v[s*DW +: DW] = DW'(base + s*step);
    return v;
  endfunction

  initial begin
    logic [8*DW-1:0] re_v, im_v;
    int gaps;
    bit fired, found;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_re = {$urandom, $urandom, $urandom, $urandom};
      in_im = {$urandom, $urandom, $urandom, $urandom};
      in_valid_br = 1'($urandom); in_valid_nr = 1'($urandom); out_ready = 1'($urandom);
    end
    #1;
    chk("rst_in_ready", 32'({in_ready_br, in_ready_nr}), 32'b11);
    chk("rst_out_valid", 32'({out_valid_br, out_valid_nr}), 32'b00);
    chk("rst_out_re", 32'({out_re_br, out_re_nr}), 32'd0);
    chk("rst_out_im", 32'({out_im_br, out_im_nr}), 32'd0);
    chk("rst_out_idx_last", 32'({out_idx_br, out_last_br, out_idx_nr, out_last_nr}), 32'd0);
    @(negedge clk);
    in_valid_br = 1'b0; in_valid_nr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2 arst_n = 1'b1;

    // Single frame, bit-reversed: re 100+s, im -(s+1)
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      re_v[s*DW +: DW] = DW'(100 + s);
      im_v[s*DW +: DW] = DW'(-(s + 1));
    end
    send(1'b0, re_v, im_v);
    #2;
    chk("lat_valid", 32'(out_valid_br), 32'd1);
    chk("lat_idx0", 32'(out_idx_br), 32'd0);
    chk("lat_re0", 32'(out_re_br), 32'd100);
    @(negedge clk);
    #2 chk("lat_re1", 32'(out_re_br), 32'd104);
    repeat (7) @(negedge clk);
    #2 chk("single_idle_after", 32'(out_valid_br), 32'd0);
    drain();

    // Back-to-back: four frames, in_valid always high
    @(negedge clk);
    fork
      begin
        for (int f = 0; f < 4; f++) send(1'b0, pack_frame(1000*(f+1), 3), pack_frame(-100*(f+1), -7));
      end
    join_none
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      #2 found = out_valid_br;
    end
    chk("b2b_start", 32'(found), 32'd1);
    gaps = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      #2 if (!out_valid_br) gaps++;
    end
    chk("b2b_gaps", 32'(gaps), 32'd0);
    drain();

    // Backpressure: two banks full, out_ready 1,0,0,1,...
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, pack_frame(16'h0200, 1), pack_frame(16'h0300, 2));
    send(1'b0, pack_frame(16'h0400, 5), pack_frame(16'h0500, 9));
    #2;
    chk("bp_full_in_ready", 32'(in_ready_br), 32'd0);
    chk("bp_full_out_valid", 32'(out_valid_br), 32'd1);
    fired = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      out_ready = pat[c % 4];
      #2 chk("bp_in_ready", 32'(in_ready_br), 32'(fired));
      if (fired) break;
      if (out_valid_br && out_ready && out_last_br) fired = 1'b1;
    end
    chk("bp_released", 32'(fired), 32'd1);
    @(negedge clk);
    send(1'b0, pack_frame(16'h0600, 11), pack_frame(16'h0700, 13));
    drain();

    // Extremes, plain slot order
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      re_v[s*DW +: DW] = (s % 2 == 0) ? 16'h7FFF : 16'h8000;
      im_v[s*DW +: DW] = 16'hFFFF;
    end
    send(1'b1, re_v, im_v);
    #2 chk("ext_re0", 32'(out_re_nr), 32'h7FFF);
    drain();

    // Mid-frame reset with the second bank full
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, pack_frame(16'h1100, 1), pack_frame(16'h1200, 1));
    send(1'b0, pack_frame(16'h1300, 1), pack_frame(16'h1400, 1));
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_idx_br == 3'd3) begin
        out_ready = 1'b0;
        found = 1'b1;
      end else begin
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("mid_reached_idx3", 32'(found), 32'd1);
    @(posedge clk);
    #2 arst_n = 1'b0;
    q_br.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_br), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_br), 32'd1);
    chk("mid_rst_out", 32'({out_re_br, out_im_br, out_idx_br}), 32'd0);
    repeat (2) @(posedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send(1'b0, pack_frame(16'h2100, 2), pack_frame(16'h2200, 4));
    #2 chk("mid_new_idx0", 32'(out_idx_br), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
